// File: rtl/crc_word_sequencer.sv
// Splits a 32-bit word into LSB-first bytes, issues one request per byte to the
// byte-wise CRC stage with the CRC chained between bytes, and returns the final CRC.
module crc_word_sequencer #(
  parameter int ID_W = 4,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [ID_W-1:0] req_id,
  input  logic [XLEN-1:0] req_data0,
  input  logic [XLEN-1:0] req_data1,
  input  logic [1:0]      req_len,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [ID_W-1:0] resp_id,
  output logic [XLEN-1:0] resp_data,
  output logic [2:0]      resp_status,
  output logic            cfu_req_valid,
  input  logic            cfu_req_ready,
  output logic [ID_W-1:0] cfu_req_id,
  output logic [XLEN-1:0] cfu_req_data0,
  output logic [XLEN-1:0] cfu_req_data1,
  input  logic            cfu_resp_valid,
  output logic            cfu_resp_ready,
  input  logic [ID_W-1:0] cfu_resp_id,
  input  logic [XLEN-1:0] cfu_resp_data,
  input  logic [2:0]      cfu_resp_status
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_word;
  logic [XLEN-1:0] r_crc;
  logic [1:0]      r_cnt;
  logic [ID_W-1:0] r_id;
  logic [2:0]      r_err;
  logic            r_req_ready;
  logic            r_resp_valid;
  logic            r_cfu_req_valid;
  logic            r_cfu_resp_ready;

  logic            w_status_err;
  logic            w_id_err;

  assign w_status_err = |cfu_resp_status;
  assign w_id_err     = (cfu_resp_id != r_id);

  // Handshake flags are registered alongside the state so each one is high
  // exactly while the FSM sits in its owning state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state          <= S_IDLE;
      r_word           <= '0;
      r_crc            <= '0;
      r_cnt            <= '0;
      r_id             <= '0;
      r_err            <= '0;
      r_req_ready      <= 1'b1;
      r_resp_valid     <= 1'b0;
      r_cfu_req_valid  <= 1'b0;
      r_cfu_resp_ready <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_word          <= req_data0;
            r_crc           <= req_data1;
            r_cnt           <= req_len;
            r_id            <= req_id;
            r_err           <= '0;
            r_req_ready     <= 1'b0;
            r_cfu_req_valid <= 1'b1;
            r_state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cfu_req_ready) begin
            r_cfu_req_valid  <= 1'b0;
            r_cfu_resp_ready <= 1'b1;
            r_state          <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cfu_resp_valid) begin
            r_crc            <= cfu_resp_data;
            r_word           <= r_word >> 8;
            r_err            <= {1'b0, r_err[1] | w_id_err, r_err[0] | w_status_err};
            r_cfu_resp_ready <= 1'b0;
            // Errors are only recorded; every byte is processed regardless.
            if (r_cnt == 2'd0) begin
              r_resp_valid <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_cnt           <= r_cnt - 2'd1;
              r_cfu_req_valid <= 1'b1;
              r_state         <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready      = r_req_ready;
  assign resp_valid     = r_resp_valid;
  assign resp_id        = r_id;
  assign resp_data      = r_crc;
  assign resp_status    = r_err;
  assign cfu_req_valid  = r_cfu_req_valid;
  assign cfu_req_id     = r_id;
  assign cfu_req_data0  = {{(XLEN-8){1'b0}}, r_word[7:0]};
  assign cfu_req_data1  = r_crc;
  assign cfu_resp_ready = r_cfu_resp_ready;

endmodule
